// File: rtl/pwm_duty_sched_if.sv
// rtl/pwm_duty_sched_if.sv - duty-word stream and period strobe between scheduler and PWM datapath
interface pwm_duty_sched_if #(
    parameter int DW = 16
);
    logic          period_end;
    logic          duty_ready;
    logic          duty_valid;
    logic [2:0]    duty_ch;
    logic [DW-1:0] duty_data;

    modport master (
        input  period_end,
        input  duty_ready,
        output duty_valid,
        output duty_ch,
        output duty_data
    );

    modport slave (
        output period_end,
        output duty_ready,
        input  duty_valid,
        input  duty_ch,
        input  duty_data
    );
endinterface

// File: rtl/pwm_duty_sched.sv
// rtl/pwm_duty_sched.sv - key-driven PWM duty scheduler streaming one duty word per channel each period
module pwm_duty_sched #(
    parameter int CH      = 6,
    parameter int DW      = 16,
    parameter int PRESC_W = 11,
    parameter int DEB_W   = 16,
    parameter int STEP    = 256
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic [6:0]       key,
    pwm_duty_sched_if.master duty,
    output logic [1:0]       mode,
    output logic [2:0]       sel
);
    localparam int NK = 5;
    localparam logic [DW-1:0]    MAX_V      = {DW{1'b1}};
    localparam logic [DW-1:0]    STEP_V     = DW'(STEP);
    localparam logic [DW-1:0]    RISE_LIM   = MAX_V - STEP_V;
    localparam logic [DW-1:0]    BRIGHT_RST = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DEB_W-1:0] DEB_MAX    = {DEB_W{1'b1}};
    localparam logic [2:0]       LAST_CH    = 3'(CH - 1);
    localparam logic [1:0]       M_OFF      = 2'd0;
    localparam logic [1:0]       M_STATIC   = 2'd1;
    localparam logic [1:0]       M_RAMP     = 2'd2;

    typedef enum logic {IDLE, SEND} state_t;

    // key[6:5] carry no function
    logic unused_keys;
    assign unused_keys = ^key[6:5];

    logic [NK-1:0]    sync1, sync2, filt, press;
    logic [DEB_W-1:0] deb_cnt [NK];

    logic [1:0]         mode_q;
    logic [2:0]         sel_q;
    logic [DW-1:0]      bright, level;
    logic               dir_fall;
    logic [CH-1:0]      en;
    logic [PRESC_W-1:0] presc;
    logic               tick;

    state_t        state, state_nxt;
    logic [2:0]    idx, idx_nxt;
    logic          snap_load;
    logic [1:0]    snap_mode;
    logic [DW-1:0] snap_bright, snap_level;
    logic [CH-1:0] snap_en;
    logic          ch_en;
    logic [DW-1:0] frame_val;

    assign mode = mode_q;
    assign sel  = sel_q;
    assign tick = &presc;

    // Synchronize, debounce and edge-detect the active-low keys; press fires on the filtered fall
    always_ff @(posedge sysclk) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
            filt  <= '1;
            press <= '0;
            for (int i = 0; i < NK; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= key[NK-1:0];
            sync2 <= sync1;
            press <= '0;
            for (int i = 0; i < NK; i++) begin
                if (sync2[i] == filt[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_MAX) begin
                    deb_cnt[i] <= '0;
                    filt[i]    <= sync2[i];
                    press[i]   <= filt[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // User controls: mode cycle, saturating brightness, channel select and per-channel enable
    always_ff @(posedge sysclk) begin
        if (rst) begin
            mode_q <= M_OFF;
            bright <= BRIGHT_RST;
            sel_q  <= 3'd0;
            en     <= '1;
        end else begin
            if (press[0]) mode_q <= (mode_q == M_RAMP) ? M_OFF : mode_q + 2'd1;
            if (press[1] && !press[2]) begin
                bright <= (bright > RISE_LIM) ? MAX_V : bright + STEP_V;
            end else if (press[2] && !press[1]) begin
                bright <= (bright < STEP_V) ? '0 : bright - STEP_V;
            end
            if (press[4]) sel_q <= (sel_q == LAST_CH) ? 3'd0 : sel_q + 3'd1;
            if (press[3]) begin
                for (int c = 0; c < CH; c++) begin
                    if (sel_q == 3'(c)) en[c] <= ~en[c];
                end
            end
        end
    end

    // Free-running prescaler; triangle ramp advances on ticks only while in RAMP
    always_ff @(posedge sysclk) begin
        if (rst) begin
            presc    <= '0;
            level    <= '0;
            dir_fall <= 1'b0;
        end else begin
            presc <= presc + 1'b1;
            if (tick && mode_q == M_RAMP) begin
                if (!dir_fall) begin
                    if (level > RISE_LIM) begin
                        level    <= MAX_V;
                        dir_fall <= 1'b1;
                    end else begin
                        level <= level + STEP_V;
                    end
                end else begin
                    if (level < STEP_V) begin
                        level    <= '0;
                        dir_fall <= 1'b0;
                    end else begin
                        level <= level - STEP_V;
                    end
                end
            end
        end
    end

    // Sequencer state register
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 3'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Sequencer next state: start a frame on period_end, advance on each accepted word
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        snap_load = 1'b0;
        case (state)
            IDLE: begin
                if (duty.period_end) begin
                    state_nxt = SEND;
                    idx_nxt   = 3'd0;
                    snap_load = 1'b1;
                end
            end
            SEND: begin
                if (duty.duty_ready) begin
                    if (idx == LAST_CH) begin
                        state_nxt = IDLE;
                        idx_nxt   = 3'd0;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame snapshot so live key/ramp updates only affect the next frame
    always_ff @(posedge sysclk) begin
        if (rst) begin
            snap_mode   <= M_OFF;
            snap_bright <= '0;
            snap_level  <= '0;
            snap_en     <= '0;
        end else if (snap_load) begin
            snap_mode   <= mode_q;
            snap_bright <= bright;
            snap_level  <= level;
            snap_en     <= en;
        end
    end

    // Duty word for the current channel, derived only from the snapshot so it holds during stalls
    always_comb begin
        ch_en = 1'b0;
        for (int c = 0; c < CH; c++) begin
            if (idx == 3'(c)) ch_en = snap_en[c];
        end
        case (snap_mode)
            M_STATIC: frame_val = snap_bright;
            M_RAMP:   frame_val = snap_level;
            default:  frame_val = '0;
        endcase
    end

    assign duty.duty_valid = (state == SEND);
    assign duty.duty_ch    = idx;
    assign duty.duty_data  = (state == SEND && ch_en) ? frame_val : '0;

endmodule

// File: doc/pwm_duty_sched.md
PWM_DUTY_SCHED -- requirements
Module: pwm_duty_sched

Interface
REQ-001 Parameter CH, default 6: number of PWM channels sequenced (2..8).
REQ-002 Parameter DW, default 16: duty word width.
REQ-003 Parameter PRESC_W, default 11: ramp tick prescaler width; one tick every 2^PRESC_W clocks.
REQ-004 Parameter DEB_W, default 16: debounce counter width; a key level is stable after 2^DEB_W clocks.
REQ-005 Parameter STEP, default 256: brightness/ramp increment, in duty LSBs.
REQ-006 SYSCLK  input  1  the single clock; all logic on rising edge.
REQ-007 RST  input  1  reset, synchronous and active-high.
REQ-008 KEY  input  7  raw active-low buttons, asynchronous: [0] mode, [1] up, [2] down, [3] enable toggle, [4] channel select, [6:5] unused.
REQ-009 PERIOD_END  input  1  one-clock pulse from the PWM datapath at each PWM period boundary.
REQ-010 DUTY_READY  input  1  PWM datapath accepts the offered duty word.
REQ-011 DUTY_VALID  output  1  duty word offered.
REQ-012 DUTY_CH  output  3  target channel of the offered word.
REQ-013 DUTY_DATA  output  DW  duty value of the offered word.
REQ-014 MODE  output  2  current mode: 0 OFF, 1 STATIC, 2 RAMP.
REQ-015 SEL  output  3  currently selected channel.

Function
REQ-016 Each KEY bit SHALL pass a 2-flop synchronizer, then a debouncer that changes its filtered level only after the synchronized level has differed from it for 2^DEB_W consecutive clocks.
REQ-017 Each filtered high-to-low transition SHALL produce exactly one single-clock press pulse; holding a key SHALL produce no further pulses.
REQ-018 Mode press SHALL cycle OFF -> STATIC -> RAMP -> OFF.
REQ-019 Up press SHALL add STEP to bright, saturating at 2^DW-1; down press SHALL subtract STEP, saturating at 0; simultaneous up and down presses SHALL leave bright unchanged.
REQ-020 Select press SHALL increment SEL, wrapping from CH-1 to 0; enable press SHALL toggle en[SEL].
REQ-021 Ramp level SHALL update only on ticks and only in RAMP: if rising and level > 2^DW-1-STEP, level := 2^DW-1 and direction becomes falling; otherwise level += STEP. If falling and level < STEP, level := 0 and direction becomes rising; otherwise level -= STEP.
REQ-022 Frame value: OFF -> 0; STATIC -> bright; RAMP -> level; a channel with en[c]=0 SHALL receive 0.
REQ-023 The sequencer FSM SHALL have states IDLE and SEND.
REQ-024 IDLE -> SEND on PERIOD_END: snapshot the mode, bright, level and en values; set channel index := 0.
REQ-025 In SEND, DUTY_VALID=1, DUTY_CH=index, and DUTY_DATA is the value for that channel taken from the snapshot.
REQ-026 A transfer completes on a clock with DUTY_VALID and DUTY_READY both high. The next channel SHALL be offered on the following clock. After channel CH-1 completes, the FSM SHALL return to IDLE with DUTY_VALID=0.
REQ-027 While DUTY_VALID=1 and DUTY_READY=0, DUTY_CH and DUTY_DATA SHALL hold stable.
REQ-028 PERIOD_END pulses arriving in SEND SHALL be ignored and not queued.
REQ-029 Key presses and ramp ticks arriving in SEND SHALL update the live registers; the changes SHALL take effect in the next frame.
REQ-030 Each frame SHALL complete in CH clocks when DUTY_READY is held high. Latency from PERIOD_END to the first DUTY_VALID SHALL be 1 clock.

Reset
REQ-031 While RST=1 on a clock edge: FSM=IDLE, DUTY_VALID=0, DUTY_CH=0, DUTY_DATA=0, MODE=OFF, SEL=0, bright=2^(DW-1), level=0, direction=rising, en=all ones, prescaler=0, debounce counters=0, filtered key levels=released (high).
REQ-032 RST asserted mid-frame SHALL abort the frame: DUTY_VALID=0 from the next clock, with no further transfers until a new PERIOD_END after reset is released.

Verification (DW=8, CH=6, PRESC_W=2, DEB_W=2, STEP=16, DUTY_READY=1 unless stated)
REQ-033 Reset, then KEY[0] low for 10 clocks -> exactly one mode press, MODE=1; PERIOD_END -> 6 consecutive transfers, CH 0..5, DUTY_DATA=128 each.
REQ-034 KEY[0] toggling every clock for 3 clocks, then held high -> no press pulse, MODE unchanged.
REQ-035 STATIC mode with 9 up presses -> bright saturates at 255; then simultaneous up and down press -> bright stays 255.
REQ-036 RAMP mode, ticks every 4 clocks -> level 0,16,...,240, then 255 with direction falling, then 239; from falling at level 15 -> 0 and direction rising.
REQ-037 Select pressed twice then enable pressed, in STATIC -> next frame has CH2 DUTY_DATA=0 and all other channels=bright; DUTY_READY low for 3 clocks during CH3 -> CH3 word held stable, 9-clock frame.
REQ-038 PERIOD_END at the first SEND clock, then RST during CH2 -> the second PERIOD_END is ignored, DUTY_VALID=0 after reset, and all REQ-031 values hold.
